// File: rtl/sync_fifo_fl.sv
// Single-clock FIFO with occupancy count, level flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_fl #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 2**ASIZE-2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 2**ASIZE;
  localparam logic [ASIZE:0] DEPTH_W = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AF_W = AFULL_LVL[ASIZE:0];
  localparam logic [ASIZE:0] AE_W = AEMPTY_LVL[ASIZE:0];
  localparam logic [ASIZE:0] ONE = {{ASIZE{1'b0}}, 1'b1};

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   count_nxt;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;
  logic             wen;
  logic             ren;

  assign waddr = wptr[ASIZE-1:0];
  assign raddr = rptr[ASIZE-1:0];
  // Acceptance looks only at registered flags, never at the other port.
  assign wen = winc && !wfull;
  assign ren = rinc && !rempty;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      wen && !ren: count_nxt = count + ONE;
      ren && !wen: count_nxt = count - ONE;
      default:     count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wen && !rst)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (wen)
        wptr <= wptr + ONE;
      if (ren)
        rptr <= rptr + ONE;
      count         <= count_nxt;
      wfull         <= (count_nxt == DEPTH_W);
      rempty        <= (count_nxt == '0);
      walmost_full  <= (count_nxt >= AF_W);
      ralmost_empty <= (count_nxt <= AE_W);
      overflow      <= overflow | (winc & wfull);
      underflow     <= underflow | (rinc & rempty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  always_comb begin
    rdata  = rempty ? '0 : mem[raddr];
    rvalid = !rempty;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      if (ren)
        rdata <= mem[raddr];
    end
  end
`endif

endmodule

// File: doc/sync_fifo_fl.md
# sync_fifo_fl

Single-clock, parametrised synchronous FIFO: the next generation of the team's clock-domain-crossing FIFO for paths where producer and consumer share one clock. It adds an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and an optional first-word-fall-through read mode. Binary pointers are used throughout because no clock crossing exists. It sits between in-domain producer/consumer pipelines and replaces the async FIFO wherever `wclk == rclk`.

## Interface
- `DSIZE`, 8, data word width in bits.
- `ASIZE`, 4, address width; depth `DEPTH = 2**ASIZE`.
- `AFULL_LVL`, `2**ASIZE-2`, `walmost_full` threshold; legal range 1..DEPTH.
- `AEMPTY_LVL`, 2, `ralmost_empty` threshold; legal range 0..DEPTH-1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wdata` in DSIZE: write data.
- `winc` in 1: write request.
- `rinc` in 1: read request.
- `rdata` out DSIZE: read data.
- `rvalid` out 1: `rdata` holds valid data (meaning is mode dependent, see Operation).
- `wfull` out 1: FIFO full (`count == DEPTH`).
- `rempty` out 1: FIFO empty (`count == 0`).
- `walmost_full` out 1: `count >= AFULL_LVL`.
- `ralmost_empty` out 1: `count <= AEMPTY_LVL`.
- `count` out ASIZE+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- Storage is a DEPTH×DSIZE register array. It is not reset.
- Pointers `wptr` and `rptr` are ASIZE+1 bits, binary, and wrap modulo 2·DEPTH. The address is the low ASIZE bits.
- A write is accepted iff `winc && !wfull`. On acceptance, `mem[waddr] <= wdata` and `wptr` increments.
- A read is accepted iff `rinc && !rempty`. On acceptance, `rptr` increments.
- Flags gate on registered state only. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- `count` update per cycle: write only → +1; read only → −1; both or neither → unchanged.
- All flags are registered and computed from the next-state `count`, so they are valid in the same cycle as `count`.
- `overflow` is set by `winc && wfull`. `underflow` is set by `rinc && rempty`. Both hold until `rst`.
- A rejected request changes no state except the sticky error flags.
- Standard mode: `rdata` is registered and loads `mem[raddr]` on an accepted read. It holds its value otherwise. `rvalid` pulses for the one cycle after an accepted read.

## Timing
- Reset values: `count`=0, `rempty`=1, `wfull`=0, `walmost_full`=0, `ralmost_empty`=1, `overflow`=0, `underflow`=0, `rdata`=0, `rvalid`=0, both pointers 0.
- A reset asserted mid-operation discards all contents within one cycle. Requests in the reset cycle are ignored.
- Write-to-flag latency: after an accepted write at edge N, `count`, `rempty` and `walmost_full` reflect it after edge N.
- Write-to-readable latency is 1 cycle. A word written at edge N can be read at edge N+1.
- Standard read latency is 1 cycle. Read accepted at edge N → `rdata` and `rvalid` are valid after edge N, for one cycle.
- Pointer wrap: after the address rolls from DEPTH−1 to 0, the pointer MSB toggles. Data order is preserved across the wrap.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined (first-word fall-through mode):
  - `rdata` = `mem[raddr]` combinationally whenever `!rempty`, and 0 when empty.
  - `rvalid` = `!rempty`.
  - `rinc` acknowledges (pops) the word currently shown.
  - The first word appears 1 cycle after the write into an empty FIFO.
- Undefined: standard registered-read mode as in Operation.
- The flags and `count` behave identically in both modes.

## Test plan
- Reset, then write 16 words `0x00..0x0F` (ASIZE=4). Check that `wfull` rises with `count`=16 and `walmost_full` rises at `count`=14. A 17th write sets `overflow`=1, and the stored data is unchanged.
- Read all 16 words. Check that `rdata` sequence = `0x00..0x0F` (standard mode: one cycle after each `rinc`). Check that `rempty`=1, `ralmost_empty`=1 at `count`≤2, and an extra `rinc` sets `underflow`=1.
- Simultaneous `winc`+`rinc` for 40 cycles at `count`=5, crossing the pointer wrap. Check that `count` stays 5 and output order matches input.
- `winc`+`rinc` while empty: write accepted, read rejected, `count`=1, `underflow`=1. `winc`+`rinc` while full: read accepted, write rejected, `count`=15, `overflow`=1.
- Assert `rst` for one cycle with `count`=9 and both sticky flags set. Check that all outputs return to their reset values the next cycle, and a subsequent write/read returns the new data.
- With `SYNC_FIFO_FWFT_EN` defined: write `0xA5` into an empty FIFO. Check that `rdata`=`0xA5` and `rvalid`=1 one cycle later with no `rinc`. After `rinc`, check that `rvalid`=0 and `rempty`=1.
